// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master/slave pair.
package i2c_pkg;

    // Master FSM states; the numeric values are visible on the debug port.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        ADDR     = 3'd2,
        ADDR_ACK = 3'd3,
        DATA     = 3'd4,
        DATA_ACK = 3'd5,
        STOP     = 3'd6,
        DONE     = 3'd7
    } i2c_state_e;

    // Slave receiver states.
    typedef enum logic [2:0] {
        SLV_IDLE     = 3'd0,
        SLV_ADDR     = 3'd1,
        SLV_ADDR_ACK = 3'd2,
        SLV_DATA     = 3'd3,
        SLV_DATA_ACK = 3'd4
    } i2c_slv_state_e;

    // R/W bit value for a write transfer.
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_master.sv
// Single-shot I2C write master: START, address+W, data byte, STOP, then
// parks in DONE until reset. Each bit is four CLK_DIV-long phases:
// SCL low, low, high, high. Line drives are pull-down enables, registered.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] addr_i,
    input  logic [7:0] data_i,
    input  logic       sda_i,
    output logic       scl_low_o,
    output logic       sda_low_o,
    output i2c_state_e state_o,
    output logic       done_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    i2c_state_e       state_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       phase_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             ack_sample_q;
    logic             scl_low_q, scl_low_d;
    logic             sda_low_q, sda_low_d;
    logic             done_q;

    // Line drive implied by the current state and phase (phase[1]=1 means SCL high).
    always_comb begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_q)
            START: sda_low_d = phase_q[1];
            ADDR, DATA: begin
                scl_low_d = !phase_q[1];
                sda_low_d = !shift_q[7];
            end
            ADDR_ACK, DATA_ACK: scl_low_d = !phase_q[1];
            STOP: begin
                scl_low_d = !phase_q[1];
                sda_low_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Master FSM with phase divider, bit counter and registered line drives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            div_q        <= '0;
            phase_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            ack_sample_q <= 1'b1;
            scl_low_q    <= 1'b0;
            sda_low_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            case (state_q)
                IDLE: begin
                    state_q <= START;
                    shift_q <= {addr_i, RW_WRITE};
                    div_q   <= '0;
                    phase_q <= '0;
                    bit_q   <= '0;
                end
                DONE: done_q <= 1'b1;
                default: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q   <= '0;
                        phase_q <= phase_q + 2'd1;
                        // End of the first high phase: SCL has been high for a while.
                        if (phase_q == 2'd2) ack_sample_q <= sda_i;
                        if (phase_q == 2'd3) begin
                            case (state_q)
                                START: state_q <= ADDR;
                                ADDR, DATA: begin
                                    shift_q <= {shift_q[6:0], 1'b0};
                                    bit_q   <= bit_q + 3'd1;
                                    if (bit_q == 3'd7)
                                        state_q <= (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                                end
                                ADDR_ACK: begin
                                    if (!ack_sample_q) begin
                                        state_q <= DATA;
                                        shift_q <= data_i;
                                    end else begin
                                        state_q <= STOP;
                                    end
                                end
                                DATA_ACK: state_q <= STOP;
                                STOP:     state_q <= DONE;
                                default:  state_q <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign scl_low_o = scl_low_q;
    assign sda_low_o = sda_low_q;
    assign state_o   = state_q;
    assign done_o    = done_q;

endmodule

// File: rtl/i2c_slave.sv
// Write-only I2C slave: watches START/STOP, shifts address and data on SCL
// rising edges, ACKs a matching write address and the data byte that follows.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           scl_i,
    input  logic           sda_i,
    output logic           sda_low_o,
    output logic [7:0]     rx_o,
    output i2c_slv_state_e state_o
);

    i2c_slv_state_e state_q;
    logic           scl_q, sda_q;
    logic [6:0]     shift_q;
    logic [2:0]     cnt_q;
    logic           sda_low_q;
    logic [7:0]     rx_q;

    logic       start_cond, stop_cond, scl_rise, scl_fall;
    logic [7:0] byte_in;

    // SDA edges only count as START/STOP when SCL is high on both samples.
    assign start_cond = scl_q && scl_i && sda_q && !sda_i;
    assign stop_cond  = scl_q && scl_i && !sda_q && sda_i;
    assign scl_rise   = !scl_q && scl_i;
    assign scl_fall   = scl_q && !scl_i;
    assign byte_in    = {shift_q, sda_i};

    // Receiver FSM: bus conditions first, then per-state bit handling.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= SLV_IDLE;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            shift_q   <= '0;
            cnt_q     <= '0;
            sda_low_q <= 1'b0;
            rx_q      <= 8'h00;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
            if (start_cond) begin
                state_q   <= SLV_ADDR;
                cnt_q     <= '0;
                sda_low_q <= 1'b0;
            end else if (stop_cond) begin
                state_q   <= SLV_IDLE;
                sda_low_q <= 1'b0;
            end else begin
                case (state_q)
                    SLV_ADDR, SLV_DATA: begin
                        if (scl_rise) begin
                            shift_q <= byte_in[6:0];
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                if (state_q == SLV_ADDR) begin
                                    state_q <= (byte_in == {SLAVE_ADDR, RW_WRITE}) ?
                                               SLV_ADDR_ACK : SLV_IDLE;
                                end else begin
                                    rx_q    <= byte_in;
                                    state_q <= SLV_DATA_ACK;
                                end
                            end
                        end
                    end
                    // First fall opens the ACK bit, second fall closes it.
                    SLV_ADDR_ACK, SLV_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_low_q) begin
                                sda_low_q <= 1'b1;
                            end else begin
                                sda_low_q <= 1'b0;
                                state_q   <= (state_q == SLV_ADDR_ACK) ? SLV_DATA : SLV_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_low_o = sda_low_q;
    assign rx_o      = rx_q;
    assign state_o   = state_q;

endmodule

// File: rtl/i2c_top.sv
// Open-drain I2C bus with one embedded master and one embedded slave.
module i2c_top
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV    = 5,
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic [7:0] rx
);

    tri1 scl;
    tri1 sda;

    logic mstr_scl_low, mstr_sda_low, slv_sda_low;

    // Debug taps: observed through the hierarchy, not consumed by the top.
    i2c_state_e     mstr_state_unused;
    logic           mstr_done_unused;
    i2c_slv_state_e slv_state_unused;

    // Agents only pull low; the tri1 nets float high otherwise (wired-AND).
    assign scl = mstr_scl_low ? 1'b0 : 1'bz;
    assign sda = (mstr_sda_low || slv_sda_low) ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV)) mstr (
        .clk_i     (clk),
        .rst_ni    (rst),
        .addr_i    (addr),
        .data_i    (data),
        .sda_i     (sda),
        .scl_low_o (mstr_scl_low),
        .sda_low_o (mstr_sda_low),
        .state_o   (mstr_state_unused),
        .done_o    (mstr_done_unused)
    );

    i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR)) slv (
        .clk_i     (clk),
        .rst_ni    (rst),
        .scl_i     (scl),
        .sda_i     (sda),
        .sda_low_o (slv_sda_low),
        .rx_o      (rx),
        .state_o   (slv_state_unused)
    );

endmodule

// File: tb/tb_i2c_top.sv
// Bench for i2c_top: directed and random single-write transactions, a bus
// monitor, and a transaction-level model of the expected bus activity.
`timescale 1ns/1ps
module tb_i2c_top;

    localparam int         CLK_DIV    = 5;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         WAIT_LIMIT = 4000;

    // ---------------- clock / reset / DUT ----------------
    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] data = 8'h00;
    logic [7:0] rx;

    always #5 clk = ~clk;

    i2c_top #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(SLAVE_ADDR)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .rx   (rx)
    );

    int compares = 0;
    int fails    = 0;

    // ---------------- bus monitor ----------------
    logic       mon_en = 1'b0;
    logic [7:0] st_obs_q[$];   // master state after each change
    logic [7:0] bit_obs_q[$];  // SDA at each SCL rising edge
    logic [7:0] ev_obs_q[$];   // SDA edges with SCL high: 0=START, 1=STOP
    int         hp_obs_q[$];   // clk cycles between consecutive SCL edges
    logic       prev_scl, prev_sda;
    int         prev_st;
    int         since;
    logic       have_edge;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
            prev_st   = 0;
            since     = 0;
            have_edge = 1'b0;
        end else begin
            since++;
            if (int'(dut.mstr.state_o) != prev_st)
                st_obs_q.push_back(8'(dut.mstr.state_o));
            prev_st = int'(dut.mstr.state_o);
            if (dut.scl !== prev_scl) begin
                if (have_edge) hp_obs_q.push_back(since);
                have_edge = 1'b1;
                since     = 0;
                if (dut.scl === 1'b1) bit_obs_q.push_back(8'(dut.sda));
            end else if (dut.scl === 1'b1 && prev_scl === 1'b1 && dut.sda !== prev_sda) begin
                ev_obs_q.push_back((dut.sda === 1'b0) ? 8'd0 : 8'd1);
            end
            prev_scl = dut.scl;
            prev_sda = dut.sda;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_st_q[$];
    logic [7:0] model_rx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b0;
        addr   = a;
        data   = d;
        repeat (2) @(negedge clk);
        model_rx = 8'h00;
        check("rst_state", 32'(dut.mstr.state_o), 32'd0);
        check("rst_done",  32'(dut.mstr.done_o), 32'd0);
        check("rst_scl",   32'(dut.scl), 32'd1);
        check("rst_sda",   32'(dut.sda), 32'd1);
        check("rst_rx",    32'(rx), 32'h00);
        st_obs_q.delete();
        bit_obs_q.delete();
        ev_obs_q.delete();
        hp_obs_q.delete();
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic finish_txn(input logic [6:0] a, input logic [7:0] d);
        int   waited;
        logic match;
        int   nbits;
        waited = 0;
        while (dut.mstr.done_o !== 1'b1 && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("done_in_time", {31'd0, waited < WAIT_LIMIT}, 32'd1);
        repeat (4) @(negedge clk);

        // Transaction-level model: what a write of d to a must look like on the bus.
        match = (a == SLAVE_ADDR);
        exp_q.delete();
        for (int i = 6; i >= 0; i--) exp_q.push_back(8'(a[i]));
        exp_q.push_back(8'd0);                    // R/W = write
        exp_q.push_back(match ? 8'd0 : 8'd1);     // address ACK / NACK
        if (match) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(8'(d[i]));
            exp_q.push_back(8'd0);                // data ACK
            model_rx = d;
        end
        exp_q.push_back(8'd0);                    // SDA low under the STOP clock
        nbits = exp_q.size();

        exp_st_q = match ? '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7}
                         : '{8'd1, 8'd2, 8'd3, 8'd6, 8'd7};

        check("bit_count", 32'(bit_obs_q.size()), 32'(nbits));
        for (int i = 0; i < nbits && i < bit_obs_q.size(); i++)
            check($sformatf("sda_bit%0d_a%0h_d%0h", i, a, d), 32'(bit_obs_q[i]), 32'(exp_q[i]));

        check("state_count", 32'(st_obs_q.size()), 32'(exp_st_q.size()));
        for (int i = 0; i < exp_st_q.size() && i < st_obs_q.size(); i++)
            check($sformatf("state_seq%0d", i), 32'(st_obs_q[i]), 32'(exp_st_q[i]));

        check("bus_event_count", 32'(ev_obs_q.size()), 32'd2);
        if (ev_obs_q.size() >= 1) check("start_event", 32'(ev_obs_q[0]), 32'd0);
        if (ev_obs_q.size() >= 2) check("stop_event",  32'(ev_obs_q[1]), 32'd1);

        check("half_period_count", 32'(hp_obs_q.size()), 32'(2 * nbits - 1));
        for (int i = 0; i < hp_obs_q.size(); i++)
            check($sformatf("half_period%0d", i), 32'(hp_obs_q[i]), 32'(2 * CLK_DIV));

        check("done_held", 32'(dut.mstr.done_o), 32'd1);
        check("rx_value",  32'(rx), 32'(model_rx));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [6:0] a;
        logic [7:0] d;
        int         waited;

        // Matching address, alternating data
        apply_reset(7'h50, 8'hA5);
        finish_txn(7'h50, 8'hA5);

        // Neighbouring address: NACK, slave keeps rx at reset value
        apply_reset(7'h51, 8'hA5);
        finish_txn(7'h51, 8'hA5);

        // Data extremes
        apply_reset(7'h50, 8'h00);
        finish_txn(7'h50, 8'h00);
        apply_reset(7'h50, 8'hFF);
        finish_txn(7'h50, 8'hFF);

        // Random transactions, roughly half aimed at the slave
        for (int n = 0; n < 4; n++) begin
            a = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
            d = 8'($urandom);
            apply_reset(a, d);
            finish_txn(a, d);
        end

        // Reset in the middle of the data byte, then a clean rerun
        d = 8'($urandom);
        apply_reset(7'h50, d);
        waited = 0;
        while (int'(dut.mstr.state_o) != 4 && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("reach_data", {31'd0, waited < WAIT_LIMIT}, 32'd1);
        repeat ($urandom_range(0, 3 * 4 * CLK_DIV)) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", 32'(dut.mstr.state_o), 32'd0);
        check("abort_scl",   32'(dut.scl), 32'd1);
        check("abort_sda",   32'(dut.sda), 32'd1);
        check("abort_done",  32'(dut.mstr.done_o), 32'd0);
        apply_reset(7'h50, d);
        finish_txn(7'h50, d);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #2ms;
        $display("FAIL watchdog: observed no completion, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
